// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style bus responder: instruction codes,
// DDRAM geometry, character constants and address helpers.
package lcd_pkg;

  localparam logic [7:0] CMD_CLR       = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h04;
  localparam logic [7:0] CMD_DISP      = 8'h08;
  localparam logic [7:0] CMD_SHIFT     = 8'h10;
  localparam logic [7:0] CMD_FUNC      = 8'h20;
  localparam logic [7:0] CMD_CGRAM     = 8'h40;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam int unsigned LINE_LEN    = 16;
  localparam int unsigned DDRAM_DEPTH = 2 * LINE_LEN;
  localparam logic [6:0] LINE0_LAST = LINE0_BASE + 7'(LINE_LEN - 1);
  localparam logic [6:0] LINE1_LAST = LINE1_BASE + 7'(LINE_LEN - 1);

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] DEG   = 8'hDF;

  typedef enum logic [3:0] {
    INS_NOP,
    INS_CLR,
    INS_HOME,
    INS_ENTRY,
    INS_DISP,
    INS_SHIFT,
    INS_FUNC,
    INS_CGRAM,
    INS_SET_DDRAM
  } lcd_ins_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEARING,
    ST_BUSY
  } lcd_state_e;

  // Instruction class is selected by the highest set bit of the byte.
  function automatic lcd_ins_e decode_ins(input logic [7:0] d);
    if (d[7])      return INS_SET_DDRAM;
    else if (d[6]) return INS_CGRAM;
    else if (d[5]) return INS_FUNC;
    else if (d[4]) return INS_SHIFT;
    else if (d[3]) return INS_DISP;
    else if (d[2]) return INS_ENTRY;
    else if (d[1]) return INS_HOME;
    else if (d[0]) return INS_CLR;
    else           return INS_NOP;
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
  endfunction

  function automatic logic [4:0] addr_to_idx(input logic [6:0] a);
    return (a < LINE1_BASE) ? {1'b0, a[3:0]} : {1'b1, a[3:0]};
  endfunction

  function automatic logic [6:0] cursor_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == LINE0_LAST)      return LINE1_BASE;
      else if (a == LINE1_LAST) return LINE0_BASE;
      else                      return a + 7'd1;
    end else begin
      if (a == LINE1_BASE)      return LINE0_LAST;
      else if (a == LINE0_BASE) return LINE1_LAST;
      else                      return a - 7'd1;
    end
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 DDRAM shadow: one write port, one registered read port, resets to spaces.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_we,
  input  logic [4:0] i_wr_idx,
  input  logic [7:0] i_wr_data,
  input  logic [4:0] i_rd_idx,
  output logic [7:0] o_rd_data
);

  logic [7:0] r_mem [DDRAM_DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DDRAM_DEPTH; i++) r_mem[i] <= SPACE;
      r_rd_data <= SPACE;
    end else begin
      if (i_we) r_mem[i_wr_idx] <= i_wr_data;
      r_rd_data <= r_mem[i_rd_idx];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/lcd_bus_sink.sv
// HD44780-style LCD bus responder: decodes controller transactions on the falling
// edge of en, executes the instruction subset and keeps a 2x16 DDRAM shadow.
module lcd_bus_sink
  import lcd_pkg::*;
#(
  parameter int unsigned CLR_BUSY = 0,
  parameter int unsigned CMD_BUSY = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rs,
  input  logic       wr,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       char_wr,
  output logic [4:0] char_idx,
  output logic [7:0] char_val,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       last_wr,
  output logic       overrun,
  output logic       bad_addr
);

  logic       r_en_q, r_rs_q, r_wr_q;
  logic [7:0] r_data_q;

  lcd_state_e r_state, w_state_nx;
  logic [31:0] r_cnt, w_cnt_nx;
  logic [4:0]  r_clr_idx, w_clr_idx_nx;
  logic [6:0]  r_cursor, w_cursor_nx;
  logic        r_inc, w_inc_nx;
  logic        r_disp, w_disp_nx, r_cur_on, w_cur_on_nx, r_blink, w_blink_nx;
  logic        r_char_wr, w_char_wr_nx;
  logic [4:0]  r_char_idx, w_char_idx_nx;
  logic [7:0]  r_char_val, w_char_val_nx;
  logic        r_last_wr, w_last_wr_nx;
  logic        r_overrun, w_overrun_nx;
  logic        r_bad_addr, w_bad_addr_nx;

  logic       w_fall;
  lcd_ins_e   w_ins;
  logic       w_go_busy;
  logic       w_we;
  logic [4:0] w_wr_idx;
  logic [7:0] w_wr_data;

  assign w_fall = r_en_q & ~en;
  assign w_ins  = decode_ins(r_data_q);

  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_clr_idx_nx  = r_clr_idx;
    w_cursor_nx   = r_cursor;
    w_inc_nx      = r_inc;
    w_disp_nx     = r_disp;
    w_cur_on_nx   = r_cur_on;
    w_blink_nx    = r_blink;
    w_char_wr_nx  = 1'b0;
    w_char_idx_nx = r_char_idx;
    w_char_val_nx = r_char_val;
    w_last_wr_nx  = r_last_wr;
    w_overrun_nx  = r_overrun;
    w_bad_addr_nx = r_bad_addr;
    w_go_busy     = 1'b0;
    w_we          = 1'b0;
    w_wr_idx      = r_clr_idx;
    w_wr_data     = SPACE;

    unique case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_last_wr_nx = r_wr_q;
          w_go_busy    = 1'b1;
          if (r_rs_q) begin
            if (addr_valid(r_cursor)) begin
              w_we          = 1'b1;
              w_wr_idx      = addr_to_idx(r_cursor);
              w_wr_data     = r_data_q;
              w_char_wr_nx  = 1'b1;
              w_char_idx_nx = addr_to_idx(r_cursor);
              w_char_val_nx = r_data_q;
              w_cursor_nx   = cursor_step(r_cursor, r_inc);
            end else begin
              w_bad_addr_nx = 1'b1;
            end
          end else begin
            unique case (w_ins)
              INS_NOP: w_go_busy = 1'b0;
              INS_CLR: begin
                w_go_busy    = 1'b0;
                w_state_nx   = ST_CLEARING;
                w_clr_idx_nx = '0;
              end
              INS_HOME:  w_cursor_nx = LINE0_BASE;
              INS_ENTRY: w_inc_nx = r_data_q[1];
              INS_DISP: begin
                w_disp_nx   = r_data_q[2];
                w_cur_on_nx = r_data_q[1];
                w_blink_nx  = r_data_q[0];
              end
              // d[3]=1 selects a display shift, which the shadow does not model.
              INS_SHIFT: if (!r_data_q[3]) w_cursor_nx = cursor_step(r_cursor, r_data_q[2]);
              INS_FUNC, INS_CGRAM: ;
              INS_SET_DDRAM: begin
                if (addr_valid(r_data_q[6:0])) w_cursor_nx = r_data_q[6:0];
                else                           w_bad_addr_nx = 1'b1;
              end
              default: ;
            endcase
          end
          if (w_go_busy && (CMD_BUSY != 0)) begin
            w_state_nx = ST_BUSY;
            w_cnt_nx   = 32'(CMD_BUSY - 1);
          end
        end
      end
      ST_CLEARING: begin
        if (w_fall) w_overrun_nx = 1'b1;
        w_we      = 1'b1;
        w_wr_idx  = r_clr_idx;
        w_wr_data = SPACE;
        if (r_clr_idx == 5'(DDRAM_DEPTH - 1)) begin
          w_cursor_nx = LINE0_BASE;
          w_inc_nx    = 1'b1;
          if (CLR_BUSY != 0) begin
            w_state_nx = ST_BUSY;
            w_cnt_nx   = 32'(CLR_BUSY - 1);
          end else begin
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_clr_idx_nx = r_clr_idx + 5'd1;
        end
      end
      ST_BUSY: begin
        if (w_fall) w_overrun_nx = 1'b1;
        if (r_cnt == '0) w_state_nx = ST_IDLE;
        else             w_cnt_nx = r_cnt - 32'd1;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_q     <= 1'b0;
      r_rs_q     <= 1'b0;
      r_wr_q     <= 1'b0;
      r_data_q   <= '0;
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_clr_idx  <= '0;
      r_cursor   <= LINE0_BASE;
      r_inc      <= 1'b1;
      r_disp     <= 1'b0;
      r_cur_on   <= 1'b0;
      r_blink    <= 1'b0;
      r_char_wr  <= 1'b0;
      r_char_idx <= '0;
      r_char_val <= '0;
      r_last_wr  <= 1'b0;
      r_overrun  <= 1'b0;
      r_bad_addr <= 1'b0;
    end else begin
      r_en_q     <= en;
      r_rs_q     <= rs;
      r_wr_q     <= wr;
      r_data_q   <= lcd_data;
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_clr_idx  <= w_clr_idx_nx;
      r_cursor   <= w_cursor_nx;
      r_inc      <= w_inc_nx;
      r_disp     <= w_disp_nx;
      r_cur_on   <= w_cur_on_nx;
      r_blink    <= w_blink_nx;
      r_char_wr  <= w_char_wr_nx;
      r_char_idx <= w_char_idx_nx;
      r_char_val <= w_char_val_nx;
      r_last_wr  <= w_last_wr_nx;
      r_overrun  <= w_overrun_nx;
      r_bad_addr <= w_bad_addr_nx;
    end
  end

  lcd_ddram u_ddram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (w_wr_data),
    .i_rd_idx  (rd_addr),
    .o_rd_data (rd_data)
  );

  assign char_wr     = r_char_wr;
  assign char_idx    = r_char_idx;
  assign char_val    = r_char_val;
  assign cursor_addr = r_cursor;
  assign disp_on     = r_disp;
  assign cursor_on   = r_cur_on;
  assign blink_on    = r_blink;
  assign busy        = (r_state != ST_IDLE);
  assign last_wr     = r_last_wr;
  assign overrun     = r_overrun;
  assign bad_addr    = r_bad_addr;

endmodule

// File: tb/tb_lcd_bus_sink.sv
// Bench for lcd_bus_sink: one instance with no busy time, one with busy time;
// char_wr pulses of the first are matched against a scoreboard queue.
module tb_lcd_bus_sink;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, rs = 1'b0, wr = 1'b0;
  logic [7:0] lcd_data = '0;
  logic [4:0] rd_addr = '0;

  logic [7:0] rd_data, char_val;
  logic       char_wr, disp_on, cursor_on, blink_on, busy, last_wr, overrun, bad_addr;
  logic [4:0] char_idx;
  logic [6:0] cursor_addr;

  logic [7:0] b_rd_data, b_char_val;
  logic       b_char_wr, b_disp_on, b_cursor_on, b_blink_on, b_busy, b_last_wr, b_overrun, b_bad_addr;
  logic [4:0] b_char_idx;
  logic [6:0] b_cursor_addr;

  int checks = 0;
  int failures = 0;
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_bus_sink dut (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .wr(wr), .lcd_data(lcd_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .char_wr(char_wr), .char_idx(char_idx), .char_val(char_val),
    .cursor_addr(cursor_addr), .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .busy(busy), .last_wr(last_wr), .overrun(overrun), .bad_addr(bad_addr)
  );

  lcd_bus_sink #(.CLR_BUSY(2), .CMD_BUSY(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .rs(rs), .wr(wr), .lcd_data(lcd_data), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .char_wr(b_char_wr), .char_idx(b_char_idx), .char_val(b_char_val),
    .cursor_addr(b_cursor_addr), .disp_on(b_disp_on), .cursor_on(b_cursor_on),
    .blink_on(b_blink_on), .busy(b_busy), .last_wr(b_last_wr), .overrun(b_overrun),
    .bad_addr(b_bad_addr)
  );

  always @(negedge clk) begin
    if (!rst && char_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL char_wr_unexpected: got idx=%0d val=%h, none expected", char_idx, char_val);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        if ({char_idx, char_val} !== e) begin
          failures++;
          $display("FAIL char_wr_data: got idx=%0d val=%h want idx=%0d val=%h",
                   char_idx, char_val, e[12:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    en = 1'b0; rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send(input logic rs_i, input logic wr_i, input logic [7:0] d);
    en = 1'b1; rs = rs_i; wr = wr_i; lcd_data = d;
    tick();
    en = 1'b0;
    tick();
  endtask

  task automatic send_char(input logic [4:0] idx, input logic [7:0] d);
    exp_q.push_back({idx, d});
    send(1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v, output logic [7:0] vb);
    rd_addr = a;
    tick();
    v = rd_data;
    vb = b_rd_data;
  endtask

  task automatic test_reset();
    logic [7:0] v, vb;
    do_reset();
    checks++;
    if ({busy, cursor_addr, disp_on, cursor_on, blink_on, char_wr, last_wr, overrun, bad_addr}
        !== {1'b0, 7'h00, 7'b0}) begin
      failures++;
      $display("FAIL reset_flags: got busy=%b cur=%h d/c/b=%b%b%b cw=%b lw=%b ov=%b ba=%b want all 0",
               busy, cursor_addr, disp_on, cursor_on, blink_on, char_wr, last_wr, overrun, bad_addr);
    end
    checks++;
    if ({char_idx, char_val} !== 13'h0) begin
      failures++;
      $display("FAIL reset_char: got idx=%0d val=%h want 0/00", char_idx, char_val);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), v, vb);
      checks++;
      if (v !== SPACE || vb !== SPACE) begin
        failures++;
        $display("FAIL reset_ddram[%0d]: got %h/%h want %h", i, v, vb, SPACE);
      end
    end
  endtask

  task automatic test_disp_ctrl();
    send(1'b0, 1'b0, 8'h0C);
    checks++;
    if ({disp_on, cursor_on, blink_on, busy} !== 4'b1000) begin
      failures++;
      $display("FAIL disp_0C: got d/c/b/busy=%b%b%b%b want 1000", disp_on, cursor_on, blink_on, busy);
    end
    send(1'b0, 1'b1, 8'h0B);
    checks++;
    if ({disp_on, cursor_on, blink_on, last_wr} !== 4'b0111) begin
      failures++;
      $display("FAIL disp_0B: got d/c/b/lw=%b%b%b%b want 0111", disp_on, cursor_on, blink_on, last_wr);
    end
  endtask

  task automatic test_clear_text();
    logic [7:0] txt [8];
    logic [7:0] v, vb;
    int n;
    txt = '{8'h31, 8'h32, 8'h2E, 8'h33, 8'h34, 8'h20, DEG, 8'h43};
    send(1'b0, 1'b0, CMD_SET_DDRAM | 8'h4A);
    send_char(5'd26, 8'h5A);
    send(1'b0, 1'b0, CMD_CLR);
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL clear_cycles: got %0d busy cycles want 32", n);
    end
    checks++;
    if (cursor_addr !== 7'h00 || last_wr !== 1'b0) begin
      failures++;
      $display("FAIL clear_cursor: got cur=%h lw=%b want 00/0", cursor_addr, last_wr);
    end
    for (int i = 0; i < 8; i++) send_char(5'(i), txt[i]);
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL text_pulses: got %0d missing char_wr want 0", exp_q.size());
    end
    checks++;
    if (cursor_addr !== 7'h08) begin
      failures++;
      $display("FAIL text_cursor: got %h want 08", cursor_addr);
    end
    for (int i = 0; i < 8; i++) begin
      rd(5'(i), v, vb);
      checks++;
      if (v !== txt[i]) begin
        failures++;
        $display("FAIL text_ddram[%0d]: got %h want %h", i, v, txt[i]);
      end
    end
    rd(5'd26, v, vb);
    checks++;
    if (v !== SPACE) begin
      failures++;
      $display("FAIL clear_ddram26: got %h want %h", v, SPACE);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] v, vb;
    send(1'b0, 1'b0, CMD_SET_DDRAM | 8'h4F);
    send_char(5'd31, 8'h41);
    send_char(5'd0, 8'h42);
    tick();
    checks++;
    if (cursor_addr !== 7'h01) begin
      failures++;
      $display("FAIL wrap_cursor: got %h want 01", cursor_addr);
    end
    rd(5'd31, v, vb);
    checks++;
    if (v !== 8'h41) begin failures++; $display("FAIL wrap_idx31: got %h want 41", v); end
    rd(5'd0, v, vb);
    checks++;
    if (v !== 8'h42) begin failures++; $display("FAIL wrap_idx0: got %h want 42", v); end
  endtask

  task automatic test_decrement();
    logic [7:0] v, vb;
    send(1'b0, 1'b0, CMD_ENTRY);
    send(1'b0, 1'b0, CMD_SET_DDRAM | 8'h40);
    send_char(5'd16, 8'h58);
    tick();
    checks++;
    if (cursor_addr !== 7'h0F) begin
      failures++;
      $display("FAIL dec_cursor: got %h want 0F", cursor_addr);
    end
    rd(5'd16, v, vb);
    checks++;
    if (v !== 8'h58) begin failures++; $display("FAIL dec_idx16: got %h want 58", v); end
    send(1'b0, 1'b0, CMD_SHIFT | 8'h04);
    checks++;
    if (cursor_addr !== 7'h40) begin
      failures++;
      $display("FAIL shift_right: got %h want 40", cursor_addr);
    end
    send(1'b0, 1'b0, CMD_SHIFT);
    checks++;
    if (cursor_addr !== 7'h0F) begin
      failures++;
      $display("FAIL shift_left: got %h want 0F", cursor_addr);
    end
  endtask

  task automatic test_bad_addr();
    send(1'b0, 1'b0, CMD_SET_DDRAM | 8'h20);
    checks++;
    if ({bad_addr, cursor_addr, busy} !== {1'b1, 7'h0F, 1'b0}) begin
      failures++;
      $display("FAIL bad_addr: got ba=%b cur=%h busy=%b want 1/0F/0", bad_addr, cursor_addr, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v, vb;
    int n;
    do_reset();
    send_char(5'd0, 8'h61);
    checks++;
    if (b_busy !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_write: got b=%b a=%b want 1/0", b_busy, busy);
    end
    send_char(5'd1, 8'h62);
    tick();
    checks++;
    if ({b_overrun, overrun, b_cursor_addr, cursor_addr} !== {1'b1, 1'b0, 7'h01, 7'h02}) begin
      failures++;
      $display("FAIL overrun: got bov=%b ov=%b bcur=%h cur=%h want 1/0/01/02",
               b_overrun, overrun, b_cursor_addr, cursor_addr);
    end
    rd(5'd1, v, vb);
    checks++;
    if (vb !== SPACE || v !== 8'h62) begin
      failures++;
      $display("FAIL overrun_idx1: got b=%h a=%h want 20/62", vb, v);
    end
    n = 0;
    while (b_busy && n < 50) begin tick(); n++; end
    checks++;
    if (b_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_timeout: got busy=%b want 0", b_busy);
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [7:0] v, vb;
    send(1'b0, 1'b0, CMD_DISP | 8'h04);
    send(1'b0, 1'b0, CMD_SET_DDRAM | 8'h44);
    send_char(5'd20, 8'h51);
    send(1'b0, 1'b0, CMD_CLR);
    repeat (3) tick();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_clear_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, b_busy, disp_on} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: got busy=%b bbusy=%b disp=%b want 000", busy, b_busy, disp_on);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, cursor_addr, char_wr, overrun, bad_addr} !== {1'b0, 7'h00, 3'b000}) begin
      failures++;
      $display("FAIL post_reset: got busy=%b cur=%h cw=%b ov=%b ba=%b want 0/00/000",
               busy, cursor_addr, char_wr, overrun, bad_addr);
    end
    rd(5'd20, v, vb);
    checks++;
    if (v !== SPACE) begin failures++; $display("FAIL post_reset_idx20: got %h want 20", v); end
  endtask

  initial begin
    test_reset();
    test_disp_ctrl();
    test_clear_text();
    test_wrap();
    test_decrement();
    test_bad_addr();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
